// File: rtl/conv_postproc_pipe_pkg.sv
// Shared definitions for the post-convolution pipeline: config map offsets,
// mode bit layout, and the saturate/round helpers used by every lane.
package conv_postproc_pipe_pkg;

  // Register map; scale/shift/mode offsets are relative to NUM_CH.
  localparam int BIAS_BASE      = 0;
  localparam int SCALE_OFS      = 0;
  localparam int SHIFT_OFS      = 1;
  localparam int MODE_OFS       = 2;
  localparam int MODE_RELU_BIT  = 0;
  localparam int MODE_ROUND_BIT = 1;
  localparam int SHIFT_W        = 5;

  typedef struct packed {
    logic round_en;
    logic relu_en;
  } mode_t;

  // Helpers work on 64-bit intermediates, so ACC_W + SCALE_W must stay below 64.
  function automatic longint sat_s(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint round_ofs(input logic [SHIFT_W-1:0] shift);
    return (shift == '0) ? 64'sd0 : (longint'(1) <<< (shift - 1));
  endfunction

endpackage

// File: rtl/conv_postproc_pipe_lane.sv
// One accumulator lane: bias add/saturate, ReLU + rescale multiply, then
// round/shift/saturate to the output width. Three registers under a shared enable.
module postproc_lane
  import conv_postproc_pipe_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 16,
  parameter int SCALE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [BIAS_W-1:0]  bias,
  input  logic                      relu_en,
  input  logic        [SCALE_W-1:0] scale,
  input  logic                      round_en,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]   res
);

  localparam int P_W = ACC_W + SCALE_W;

  logic signed [ACC_W-1:0] sum_q, sum_d, relu_w;
  logic signed [P_W-1:0]   prod_q, prod_d;
  logic signed [OUT_W-1:0] res_d;
  longint                  sum_wide, scaled;

  // NOTE: combinational logic uses blocking '=' so later lines see the value
  // just computed; every variable is assigned on every pass, so no latch forms.
  always_comb begin
    sum_wide = longint'(acc) + longint'(bias);
    sum_d    = ACC_W'(sat_s(sum_wide, ACC_W));
    relu_w   = (relu_en && sum_q[ACC_W-1]) ? '0 : sum_q;
    // Scale is unsigned: zero-extend it so the product stays signed-correct.
    prod_d   = $signed({{SCALE_W{relu_w[ACC_W-1]}}, relu_w})
             * $signed({{ACC_W{1'b0}}, scale});
    scaled   = longint'(prod_q) + (round_en ? round_ofs(shift) : 64'sd0);
    res_d    = OUT_W'(sat_s(scaled >>> shift, OUT_W));
  end

  // NOTE: sequential state uses non-blocking '<=' so all stages update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      prod_q <= '0;
      res    <= '0;
    end else if (en) begin
      sum_q  <= sum_d;
      prod_q <= prod_d;
      res    <= res_d;
    end
  end

endmodule

// File: rtl/conv_postproc_pipe.sv
// Post-convolution pipeline top: config registers, per-beat config snapshot,
// valid chain with back-pressure, sticky channel error, and LANES lane datapaths.
module conv_postproc_pipe
  import conv_postproc_pipe_pkg::*;
#(
  parameter int LANES   = 40,
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 16,
  parameter int SCALE_W = 16,
  parameter int OUT_W   = 8,
  parameter int NUM_CH  = 32,
  parameter int CFG_AW  = $clog2(NUM_CH + 3)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [CFG_AW-1:0]         cfg_addr,
  input  logic [31:0]               cfg_wdata,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(NUM_CH)-1:0] in_ch,
  input  logic [LANES*ACC_W-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic                      err_o
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int SHIFT_MAX = (1 << SHIFT_W) - 1;
  localparam int MAX_SHIFT = (ACC_W + SCALE_W - 1 < SHIFT_MAX) ? ACC_W + SCALE_W - 1 : SHIFT_MAX;

  logic signed [BIAS_W-1:0]  bias_tbl [NUM_CH];
  logic        [SCALE_W-1:0] scale_q;
  logic        [SHIFT_W-1:0] shift_q;
  mode_t                     mode_q;

  logic               bias_we, scale_we, shift_we, mode_we;
  logic [SHIFT_W-1:0] shift_wr;
  logic               wdata_unused;

  assign bias_we  = cfg_we && (int'(cfg_addr) < BIAS_BASE + NUM_CH);
  assign scale_we = cfg_we && (int'(cfg_addr) == NUM_CH + SCALE_OFS);
  assign shift_we = cfg_we && (int'(cfg_addr) == NUM_CH + SHIFT_OFS);
  assign mode_we  = cfg_we && (int'(cfg_addr) == NUM_CH + MODE_OFS);
  assign shift_wr = (int'(cfg_wdata[SHIFT_W-1:0]) > MAX_SHIFT) ? SHIFT_W'(MAX_SHIFT)
                                                              : cfg_wdata[SHIFT_W-1:0];
  assign wdata_unused = ^cfg_wdata;

  // NOTE: the bias table is a flop array, not RAM, because its entries have a
  // defined reset value; every entry is cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) bias_tbl[i] <= '0;
      scale_q         <= SCALE_W'(1);
      shift_q         <= '0;
      mode_q.relu_en  <= 1'b1;
      mode_q.round_en <= 1'b0;
    end else begin
      if (bias_we)  bias_tbl[cfg_addr[CH_W-1:0]] <= cfg_wdata[BIAS_W-1:0];
      if (scale_we) scale_q <= cfg_wdata[SCALE_W-1:0];
      if (shift_we) shift_q <= shift_wr;
      if (mode_we) begin
        mode_q.relu_en  <= cfg_wdata[MODE_RELU_BIT];
        mode_q.round_en <= cfg_wdata[MODE_ROUND_BIT];
      end
    end
  end

  logic                     adv_en, accept, ch_ok;
  logic signed [BIAS_W-1:0] bias_sel;
  logic                     s1_valid, s2_valid;
  logic        [SCALE_W-1:0] s1_scale;
  logic        [SHIFT_W-1:0] s1_shift, s2_shift;
  mode_t                     s1_mode;
  logic                      s2_round;

  assign adv_en   = !out_valid || out_ready;
  assign in_ready = adv_en;
  assign accept   = in_valid && adv_en;
  assign ch_ok    = int'(in_ch) < NUM_CH;
  assign bias_sel = ch_ok ? bias_tbl[in_ch] : '0;

  // Bias is consumed in stage 1; the rest of the snapshot travels with the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_scale  <= '0;
      s1_shift  <= '0;
      s1_mode   <= '0;
      s2_shift  <= '0;
      s2_round  <= 1'b0;
    end else if (adv_en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      s1_scale  <= scale_q;
      s1_shift  <= shift_q;
      s1_mode   <= mode_q;
      s2_shift  <= s1_shift;
      s2_round  <= s1_mode.round_en;
    end
  end

  // A fresh bad-channel acceptance wins over a simultaneous clearing mode write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_o <= 1'b0;
    else if (accept && !ch_ok)  err_o <= 1'b1;
    else if (mode_we)           err_o <= 1'b0;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    postproc_lane #(
      .ACC_W  (ACC_W),
      .BIAS_W (BIAS_W),
      .SCALE_W(SCALE_W),
      .OUT_W  (OUT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv_en),
      .acc     (in_data[i*ACC_W +: ACC_W]),
      .bias    (bias_sel),
      .relu_en (s1_mode.relu_en),
      .scale   (s1_scale),
      .round_en(s2_round),
      .shift   (s2_shift),
      .res     (out_data[i*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_conv_postproc_pipe.sv
// Self-checking bench for conv_postproc_pipe: table-driven vectors plus
// hand-written latency, snapshot, error, back-pressure and reset sequences.
module tb_conv_postproc_pipe;

  localparam int LANES   = 4;
  localparam int ACC_W   = 32;
  localparam int BIAS_W  = 16;
  localparam int SCALE_W = 16;
  localparam int OUT_W   = 8;
  localparam int NUM_CH  = 24;
  localparam int CFG_AW  = $clog2(NUM_CH + 3);
  localparam int CH_W    = $clog2(NUM_CH);

  typedef logic [LANES*ACC_W-1:0] data_t;
  typedef logic [LANES*OUT_W-1:0] out_t;

  typedef struct {
    int    ch;
    int    bias;
    int    scale;
    int    shift;
    bit    relu;
    bit    rnd;
    data_t d;
    out_t  e;
  } vec_t;

  logic              clk, rst_n, cfg_we, in_valid, in_ready, out_valid, out_ready, err_o;
  logic [CFG_AW-1:0] cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [CH_W-1:0]   in_ch;
  data_t             in_data;
  out_t              out_data;

  conv_postproc_pipe #(
    .LANES(LANES), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .SCALE_W(SCALE_W),
    .OUT_W(OUT_W), .NUM_CH(NUM_CH), .CFG_AW(CFG_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  out_t exp_q[$];

  int sh_bias [NUM_CH];
  int sh_scale, sh_shift;
  bit sh_relu, sh_round;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic data_t pack_d(input int a, input int b, input int c, input int e);
    data_t r;
    r[0*ACC_W +: ACC_W] = a;
    r[1*ACC_W +: ACC_W] = b;
    r[2*ACC_W +: ACC_W] = c;
    r[3*ACC_W +: ACC_W] = e;
    return r;
  endfunction

  function automatic out_t pack_o(input int a, input int b, input int c, input int e);
    out_t r;
    r[0*OUT_W +: OUT_W] = 8'(a);
    r[1*OUT_W +: OUT_W] = 8'(b);
    r[2*OUT_W +: OUT_W] = 8'(c);
    r[3*OUT_W +: OUT_W] = 8'(e);
    return r;
  endfunction

  function automatic vec_t mkvec(input int ch, input int bias, input int scale, input int shift,
                                 input bit relu, input bit rnd,
                                 input int d0, input int d1, input int d2, input int d3,
                                 input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.ch = ch; v.bias = bias; v.scale = scale; v.shift = shift; v.relu = relu; v.rnd = rnd;
    v.d = pack_d(d0, d1, d2, d3);
    v.e = pack_o(e0, e1, e2, e3);
    return v;
  endfunction

  // Behavioural reference using the bench's own copy of the configuration.
  function automatic out_t model(input int ch, input data_t d);
    longint b, s;
    out_t   r;
    b = (ch < NUM_CH) ? longint'(sh_bias[ch]) : 0;
    for (int i = 0; i < LANES; i++) begin
      s = longint'($signed(d[i*ACC_W +: ACC_W])) + b;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      if (sh_relu && s < 0) s = 0;
      s = s * longint'(sh_scale);
      if (sh_round && sh_shift > 0) s = s + (longint'(1) <<< (sh_shift - 1));
      s = s >>> sh_shift;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      r[i*OUT_W +: OUT_W] = s[7:0];
    end
    return r;
  endfunction

  task automatic shadow_reset();
    for (int i = 0; i < NUM_CH; i++) sh_bias[i] = 0;
    sh_scale = 1; sh_shift = 0; sh_relu = 1'b1; sh_round = 1'b0;
  endtask

  task automatic shadow_write(input int addr, input logic [31:0] wd);
    if (addr < NUM_CH)            sh_bias[addr] = int'($signed(wd[15:0]));
    else if (addr == NUM_CH)      sh_scale = int'(wd[15:0]);
    else if (addr == NUM_CH + 1)  sh_shift = int'(wd[4:0]);
    else if (addr == NUM_CH + 2) begin sh_relu = wd[0]; sh_round = wd[1]; end
  endtask

  // One clock of stimulus: optional config write and optional beat.
  task automatic step(input bit we, input int addr, input logic [31:0] wd,
                      input bit v, input int ch, input data_t d, input out_t e, output bit acc);
    cfg_we = we; cfg_addr = CFG_AW'(addr); cfg_wdata = wd;
    in_valid = v; in_ch = CH_W'(ch); in_data = d;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) exp_q.push_back(e);
    @(posedge clk); #1;
    if (we) shadow_write(addr, wd);
    cfg_we = 1'b0; in_valid = 1'b0;
  endtask

  task automatic cfg(input int addr, input logic [31:0] wd);
    bit acc;
    step(1'b1, addr, wd, 1'b0, 0, '0, '0, acc);
  endtask

  task automatic send(input int ch, input data_t d, input out_t e);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      step(1'b0, 0, '0, 1'b1, ch, d, e, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    acc;
    data_t d;
    out_t  held;
    int    n0, stale;
    vec_t  vecs[7];

    vecs[0] = mkvec(3, 10, 1, 0, 1, 0, -20, 5, 100, 200, 0, 15, 110, 127);
    vecs[1] = mkvec(0, 0, 3, 2, 0, 1, -5, 7, 1, -100, -4, 5, 1, -75);
    vecs[2] = mkvec(0, 0, 3, 2, 0, 0, -5, 7, 1, -100, -4, 5, 0, -75);
    vecs[3] = mkvec(1, 1, 1, 30, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFE, 0, -1, 1, 1, 0, 0);
    vecs[4] = mkvec(2, -1, 1, 30, 0, 0, 32'h80000000, 32'h80000001, 5, -7, -2, -2, 0, -1);
    vecs[5] = mkvec(5, -3, 1000, 4, 0, 1, 100, -1, 2, 0, 127, -128, -62, -128);
    vecs[6] = mkvec(7, 0, 5, 1, 1, 1, -9, 9, 25, 0, 0, 23, 63, 0);

    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
    shadow_reset();

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Latency with default config
    d = pack_d(-20, 5, 100, 200);
    step(1'b0, 0, '0, 1'b1, 3, d, model(3, d), acc);
    check("lat_accept", acc, 1);
    @(negedge clk); check("lat_cycle1", out_valid, 0);
    @(negedge clk); check("lat_cycle2", out_valid, 0);
    @(negedge clk); check("lat_cycle3", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      cfg(vecs[i].ch, 32'(vecs[i].bias));
      cfg(NUM_CH, 32'(vecs[i].scale));
      cfg(NUM_CH + 1, 32'(vecs[i].shift));
      cfg(NUM_CH + 2, {30'b0, vecs[i].rnd, vecs[i].relu});
      send(vecs[i].ch, vecs[i].d, vecs[i].e);
      drain();
    end

    // Snapshot: later writes, including same-cycle ones, do not reach earlier beats
    cfg(NUM_CH + 2, 0); cfg(NUM_CH, 1); cfg(NUM_CH + 1, 0); cfg(0, 0);
    d = pack_d(20, -20, 1, 100);
    step(1'b0, 0, '0, 1'b1, 0, d, pack_o(20, -20, 1, 100), acc);
    check("snap_a_accept", acc, 1);
    step(1'b1, 0, 32'd50, 1'b0, 0, d, '0, acc);
    step(1'b1, NUM_CH, 32'd2, 1'b1, 0, d, pack_o(70, 30, 51, 127), acc);
    check("snap_b_accept", acc, 1);
    step(1'b1, 0, -32'sd30, 1'b1, 0, d, pack_o(127, 60, 102, 127), acc);
    check("snap_c_accept", acc, 1);
    step(1'b0, 0, '0, 1'b1, 0, d, pack_o(-20, -100, -58, 127), acc);
    check("snap_d_accept", acc, 1);
    drain();

    // Out-of-range channel: bias 0, sticky error cleared only by a mode write
    cfg(NUM_CH + 2, 0);
    check("err_clear_init", err_o, 0);
    cfg(NUM_CH, 1); cfg(NUM_CH + 1, 0); cfg(0, 55); cfg(8, 77);
    d = pack_d(3, -3, 300, -300);
    send(NUM_CH, d, pack_o(3, -3, 127, -128));
    drain();
    check("err_set", err_o, 1);
    send(2, d, model(2, d));
    drain();
    check("err_sticky_beat", err_o, 1);
    cfg(NUM_CH, 2);
    check("err_sticky_scale", err_o, 1);
    cfg(NUM_CH + 3, 32'hFFFF_FFFF);
    send(0, d, model(0, d));
    drain();
    check("err_sticky_unmapped", err_o, 1);
    cfg(NUM_CH + 2, 0);
    check("err_cleared_by_mode", err_o, 0);

    // Back-pressure: 8 beats, out_ready low for 5 cycles mid-stream
    cfg(4, -32'sd7); cfg(NUM_CH, 2); cfg(NUM_CH + 1, 1); cfg(NUM_CH + 2, 0);
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          data_t bd;
          bd = pack_d($urandom_range(400) - 200, $urandom_range(400) - 200,
                      $urandom_range(400) - 200, i * 20 - 70);
          send(4, bd, model(4, bd));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        held = out_data;
        check("bp_valid_at_stall", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 0);
          check("bp_out_valid_held", out_valid, 1);
          check("bp_out_data_stable", out_data, held);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_beat_count", n_out - n0, 8);

    // Reset mid-stream with three beats in flight
    cfg(3, 10); cfg(NUM_CH, 3);
    d = pack_d(40, -40, 7, 9);
    step(1'b0, 0, '0, 1'b1, 3, d, model(3, d), acc);
    step(1'b0, 0, '0, 1'b1, 3, d, model(3, d), acc);
    step(1'b0, 0, '0, 1'b1, NUM_CH, d, model(NUM_CH, d), acc);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_err", err_o, 0);
    exp_q.delete();
    shadow_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);
    @(posedge clk); #1;
    d = pack_d(-20, 5, 100, 200);
    send(3, d, pack_o(0, 5, 100, 127));
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
